// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C bus constants and master FSM state encoding.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ = 1'b1;
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_WDATA,
        ST_RACK2,
        ST_RDATA,
        ST_MNACK,
        ST_STOP,
        ST_DONE
    } i2c_state_e;
endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: one-cycle tick every CLK_DIV clocks, restartable so quarters align to a command.
module i2c_qtick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic qtick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign qtick = cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (restart || qtick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-byte I2C master running START, address, one data byte and STOP.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [I2C_ADDR_W-1:0] addr,
    input  logic                  rw,
    input  logic [7:0]            wdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err,
    output logic [7:0]            rdata,
    inout  wire                   sda,
    inout  wire                   scl
);
    i2c_state_e state, nxt;
    logic [1:0] q;
    logic [2:0] bitn;
    logic [I2C_ADDR_W-1:0] c_addr;
    logic [7:0] c_wdata, hold, tx;
    logic c_rw, smp, qtick, accept, slot_end, sda_oe, scl_oe, shift_st;
    assign ready = state == ST_IDLE || state == ST_DONE;
    assign busy = !ready;
    assign done = state == ST_DONE;
    assign accept = start && ready;
    assign slot_end = qtick && q == 2'd3;
    assign shift_st = state == ST_ADDR || state == ST_WDATA || state == ST_RDATA;
    assign tx = state == ST_ADDR ? {c_addr, c_rw} : c_wdata;
    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk(clk),
        .rst_n(rst_n),
        .restart(accept),
        .qtick(qtick)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE: nxt = start ? ST_START : ST_IDLE;
            ST_START: nxt = slot_end ? ST_ADDR : state;
            ST_ADDR: nxt = slot_end && bitn == 3'd7 ? ST_ACK1 : state;
            ST_ACK1: nxt = !slot_end ? state : smp == I2C_NACK ? ST_STOP :
                           c_rw == I2C_READ ? ST_RDATA : ST_WDATA;
            ST_WDATA: nxt = slot_end && bitn == 3'd7 ? ST_RACK2 : state;
            ST_RACK2: nxt = slot_end ? ST_STOP : state;
            ST_RDATA: nxt = slot_end && bitn == 3'd7 ? ST_MNACK : state;
            ST_MNACK: nxt = slot_end ? ST_STOP : state;
            ST_STOP: nxt = slot_end ? ST_DONE : state;
            default: nxt = ST_IDLE;
        endcase
    end
    // SDA is sampled entering q3, while SCL has been released for a full quarter.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q <= '0;
            bitn <= '0;
            c_addr <= '0;
            c_rw <= I2C_WRITE;
            c_wdata <= '0;
            hold <= '0;
            smp <= I2C_NACK;
            ack_err <= 1'b0;
            rdata <= '0;
        end else if (accept) begin
            q <= '0;
            bitn <= '0;
            c_addr <= addr;
            c_rw <= rw;
            c_wdata <= wdata;
            ack_err <= 1'b0;
        end else if (qtick && busy) begin
            q <= q + 2'd1;
            if (q == 2'd2) smp <= sda;
            if (q == 2'd2 && state == ST_RDATA) hold <= {hold[6:0], sda};
            if (slot_end) bitn <= shift_st ? bitn + 3'd1 : 3'd0;
            if (slot_end && (state == ST_ACK1 || state == ST_RACK2) && smp == I2C_NACK) ack_err <= 1'b1;
            if (slot_end && state == ST_MNACK) rdata <= hold;
        end
    always_comb begin
        scl_oe = state == ST_START ? q == 2'd3 : busy && !q[1];
        sda_oe = state == ST_START ? q[1] : state == ST_STOP ? q != 2'd3 :
                 (state == ST_ADDR || state == ST_WDATA) && !tx[~bitn];
    end
    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign scl = scl_oe ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_master_byte.sv
// tb_i2c_master_byte: two masters (CLK_DIV=4 and CLK_DIV=1) on one bus with a behavioural slave at 7'h14.
module tb_i2c_master_byte;
    localparam int DIV = 4;
    localparam logic [6:0] SLV = 7'h14;
    typedef struct {
        logic rw;
        logic ack;
        logic [7:0] rd;
        logic [7:0] wb;
        int lat;
        int rises;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw = 1'b0, sel = 1'b0, s_oe = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0, rbyte = 8'h9C, exp_rd = '0;
    logic ready0, busy0, done0, ack0, ready1, busy1, done1, ack1;
    logic [7:0] rdata0, rdata1;
    logic rdy, dn, acke;
    logic [7:0] rdm;
    logic [7:0] s_ab = '0, s_rx = '0;
    logic s_mnack = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
    int checks = 0, failures = 0, cyc = 0, acc = 0, bc = 0, n_start = 0, n_stop = 0;
    exp_t sb[$];
    exp_t em;
    wire sda, scl;
    pullup (sda);
    pullup (scl);
    assign sda = s_oe ? 1'b0 : 1'bz;
    assign rdy = sel ? ready1 : ready0;
    assign dn = sel ? done1 : done0;
    assign acke = sel ? ack1 : ack0;
    assign rdm = sel ? rdata1 : rdata0;
    i2c_master_byte #(.CLK_DIV(DIV)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .addr(addr), .rw(rw), .wdata(wdata),
        .ready(ready0), .busy(busy0), .done(done0), .ack_err(ack0), .rdata(rdata0),
        .sda(sda), .scl(scl)
    );
    i2c_master_byte #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .addr(addr), .rw(rw), .wdata(wdata),
        .ready(ready1), .busy(busy1), .done(done1), .ack_err(ack1), .rdata(rdata1),
        .sda(sda), .scl(scl)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic exp_t model(input logic [6:0] a, input logic r, input logic [7:0] w);
        exp_t e;
        logic hit = a == SLV;
        e.rw = r;
        e.ack = !hit;
        e.wb = w;
        e.lat = (hit ? 80 : 44) * (sel ? 1 : DIV);
        // bit clocks plus the SCL release of STOP
        e.rises = hit ? 19 : 10;
        if (hit && r) exp_rd = rbyte;
        e.rd = exp_rd;
        return e;
    endfunction
    // Slave model, protocol checker and scoreboard consumer.
    always @(negedge clk) begin
        if (!rst_n) begin
            s_oe = 1'b0;
            bc = 0;
            n_start = 0;
            n_stop = 0;
            sb.delete();
        end else begin
            if (scl && p_scl && p_sda && !sda) begin
                n_start++;
                bc = 0;
                s_oe = 1'b0;
            end else if (scl && p_scl && !p_sda && sda) n_stop++;
            else if (!p_scl && scl) begin
                bc++;
                if (bc <= 8) s_ab = {s_ab[6:0], sda};
                if (bc >= 10 && bc <= 17 && !s_ab[0]) s_rx = {s_rx[6:0], sda};
                if (bc == 18) s_mnack = sda;
            end else if (p_scl && !scl) begin
                if (bc == 8) s_oe = s_ab[7:1] == SLV;
                else if (bc >= 9 && bc <= 16 && s_ab[7:1] == SLV && s_ab[0]) s_oe = !rbyte[16 - bc];
                else s_oe = bc == 17 && s_ab[7:1] == SLV && !s_ab[0];
            end
            if (dn) begin
                chk("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    em = sb.pop_front();
                    chk("ack_err", acke, em.ack);
                    chk("rdata", rdm, em.rd);
                    chk("latency", cyc - acc, em.lat);
                    chk("scl_rises", bc, em.rises);
                    chk("start_cnt", n_start, 1);
                    chk("stop_cnt", n_stop, 1);
                    if (!em.ack && !em.rw) chk("slave_rx", s_rx, em.wb);
                    if (!em.ack && em.rw) chk("master_nack", s_mnack, 1);
                end
                n_start = 0;
                n_stop = 0;
            end
            if (start && rdy) acc = cyc + 1;
        end
        p_scl = scl;
        p_sda = sda;
    end
    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w);
        int n = 0;
        while (!rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", rdy, 1);
        @(posedge clk);
        #2;
        addr = a;
        rw = r;
        wdata = w;
        start = 1'b1;
        sb.push_back(model(a, r, w));
        @(posedge clk);
        #2 start = 1'b0;
    endtask
    task automatic drain(input int lim);
        int n = 0;
        while ((sb.size() != 0 || !rdy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", ready0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ack_err", ack0, 0);
        chk("rst_rdata", rdata0, 8'h00);
        chk("rst_sda", sda, 1);
        chk("rst_scl", scl, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        issue(SLV, 1'b0, 8'hA5);
        drain(2000);
        issue(SLV, 1'b1, 8'h00);
        drain(2000);
        issue(7'h15, 1'b0, 8'h33);
        drain(2000);
        // start pulses in the middle of a read must not be queued
        rbyte = 8'h6B;
        issue(SLV, 1'b1, 8'h00);
        repeat (40) @(posedge clk);
        #2;
        addr = 7'h15;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        drain(2000);
        repeat (200) @(negedge clk);
        chk("ignored_idle_ready", ready0, 1);
        // reset during the address phase
        issue(SLV, 1'b0, 8'h11);
        for (int n = 0; bc != 5 && n < 2000; n++) @(negedge clk);
        chk("reached_addr_slot5", bc, 5);
        #3 rst_n = 1'b0;
        exp_rd = 8'h00;
        #1;
        chk("abort_sda", sda, 1);
        chk("abort_scl", scl, 1);
        chk("abort_busy", busy0, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ready0, 1);
        chk("post_rst_rdata", rdata0, 8'h00);
        issue(SLV, 1'b0, 8'h3E);
        drain(2000);
        // CLK_DIV=1 back-to-back write then read with start held through done
        sel = 1'b1;
        rbyte = 8'hC4;
        @(posedge clk);
        #2;
        addr = SLV;
        rw = 1'b0;
        wdata = 8'h5A;
        start = 1'b1;
        sb.push_back(model(SLV, 1'b0, 8'h5A));
        @(posedge clk);
        #2;
        rw = 1'b1;
        sb.push_back(model(SLV, 1'b1, 8'h00));
        for (int n = 0; !done1 && n < 500; n++) @(negedge clk);
        chk("b2b_first_done", done1, 1);
        chk("b2b_ready_in_done", ready1, 1);
        @(posedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_after_done", busy1, 1);
        drain(500);
        repeat (50) @(negedge clk);
        chk("final_queue", sb.size(), 0);
        chk("final_ready", ready1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Clocked single-byte I2C master: the upstream stage that generates START, address, data and STOP on the shared open-drain `sda`/`scl` bus for the team's I2C slave peripherals. A host issues one command (7-bit address, R/W, write byte). The block runs the complete bus transaction, then returns the read byte and the ACK status. Clock stretching and multi-master arbitration are out of scope.

## Interface
- `CLK_DIV`, default 250: system clocks per SCL quarter-period. Legal range ≥1. SCL period = 4·CLK_DIV clocks.
- `clk`  in  1  system clock. Single clock domain; all logic is posedge `clk`.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  command request. Accepted only in a cycle with `ready`=1.
- `addr`  in  7  target slave address. Latched on accept.
- `rw`  in  1  0=write, 1=read. Latched on accept.
- `wdata`  in  8  byte to write. Latched on accept; ignored for reads.
- `ready`  out  1  idle; a command can be accepted.
- `busy`  out  1  transaction in progress (equals ~`ready`).
- `done`  out  1  one-cycle pulse when the transaction ends.
- `ack_err`  out  1  slave NACKed the address or the write byte. Valid with `done`; held until the next accept.
- `rdata`  out  8  byte read from the slave. Valid with `done` when `rw`=1; held until the next read completes.
- `sda`  inout  1  open-drain data. Driven to 0 or released (z) only.
- `scl`  inout  1  open-drain clock. Driven to 0 or released (z) only.

## Operation
- Reset values: `ready`=1, `busy`=0, `done`=0, `ack_err`=0, `rdata`=8'h00, `sda`/`scl` released. Asserting reset mid-transaction releases both lines immediately. No STOP is generated.
- A free-running quarter tick, `qtick`, fires every CLK_DIV clocks. It restarts at 0 on accept, so the first quarter is aligned to the command. All FSM activity advances on `qtick`.
- Each bit slot is 4 quarters:
  - q0: SCL low; SDA updated.
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL high; the read sample is taken at the start of q3.
- States:
  - IDLE: on `start`&`ready`, latch the command, set `ack_err`=0, go to START.
  - START (4 quarters): SDA and SCL released for q0–q1. SDA low at q2 while SCL is high. SCL low at q3.
  - ADDR: 8 slots, MSB first. Bits are {addr[6:0], rw}.
  - ACK1: release SDA for 1 slot and sample it. 1 → `ack_err`=1 and go to STOP. 0 → WDATA if `rw`=0, else RDATA.
  - WDATA: 8 slots of `wdata`, MSB first.
  - RACK2 (write): release SDA and sample it. 1 → `ack_err`=1. Then go to STOP.
  - RDATA: SDA released for 8 slots. Shift in MSB first into a holding register.
  - MNACK (read): master releases SDA for 1 slot, which signals NACK to end the read. Copy the holding register to `rdata`. Go to STOP.
  - STOP (4 quarters): SDA low with SCL low for q0–q1. SCL released at q2. SDA released at q3.
  - DONE: pulse `done` for one clock, set `ready`=1, go to IDLE.
- `start` while busy is ignored and not queued.
- A logical 1 on SDA is always a release, never a drive.

## Timing
- Successful transaction, write or read: 20 slots (START + 9 + 9 + STOP) = 80·CLK_DIV clocks from accept to `done`.
- Address NACK: 11 slots = 44·CLK_DIV clocks. No data phase.
- `ready` drops on the clock after accept. It rises in the same cycle as the `done` pulse.
- `start` asserted in the same cycle that `done` pulses is accepted, since `ready`=1 there. This gives back-to-back transactions with no extra gap.
- SDA changes only while SCL is low, except at START and STOP.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum.
  - `I2C_ADDR_W`=7.
  - `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1.
  - R/W encoding constants, also used by the slave side.
- Sub-module `i2c_qtick_gen`: CLK_DIV counter with synchronous restart, output `qtick`.
- Top level: FSM, slot/quarter counters, shift registers, open-drain output enables.

## Test plan
- Write, slave model at address 7'h14 ACKing: addr=7'h14, rw=0, wdata=8'hA5 → slave receives 8'hA5; `done` after 80·CLK_DIV clocks; `ack_err`=0.
- Read, slave model returns 8'h9C: addr=7'h14, rw=1 → `rdata`=8'h9C; master NACK seen on the 9th data clock; `ack_err`=0.
- Address NACK: addr=7'h15, no device → `ack_err`=1; `done` after 44·CLK_DIV clocks; no data clocks on SCL.
- Protocol checker over all runs:
  - exactly one START and one STOP per command;
  - SDA stable while SCL is high between them;
  - `start` while busy is ignored.
- Reset at slot 5 of ADDR: both lines released within the reset assertion; `ready`=1 after release; a subsequent write completes normally.
- CLK_DIV=1, back-to-back write then read with `start` held during `done`: both complete; the second accept occurs in the `done` cycle.
